trigger_sequencer: RTL and testbench

Multi-channel, phase-offset trigger generator for the SPI ADC acquisition path. It is the parametrised successor of the single-output divider trigger. One shared period counter drives CHANNELS trigger outputs, each firing at its own phase within the period. The block runs in continuous or fixed-length burst mode under start/stop control, and reports busy/done status to the register interface.

---
 rtl/trigger_pkg.sv | 13 +
 rtl/trigger_sync_edge.sv | 32 +++
 rtl/trigger_sequencer.sv | 128 ++++++++++++
 tb/tb_trigger_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared constants and state encoding for the trigger sequencer.
package trigger_pkg;

  localparam int unsigned TRIG_CNT_WIDTH    = 32;
  localparam int unsigned TRIG_BURST_WIDTH  = 16;
  localparam int unsigned TRIG_MAX_CHANNELS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } trig_state_e;

endpackage

// File: rtl/trigger_sync_edge.sv
// Two-flop synchronizer with a rising-edge pulse output.
// Only compiled when TRIGGER_SEQ_SYNC_EN is defined.
`ifdef TRIGGER_SEQ_SYNC_EN
module trigger_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic sync_d1_q;

  // Synchronizer chain plus one delay stage for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      sync_d1_q <= 1'b0;
    end else begin
      meta_q    <= async_in;
      sync_q    <= meta_q;
      sync_d1_q <= sync_q;
    end
  end

  // One-cycle pulse on the synchronized rising edge
  assign rise_c = sync_q & ~sync_d1_q;

endmodule
`endif

// File: rtl/trigger_sequencer.sv
// Multi-channel phase-offset trigger generator with continuous/burst modes.
// Optional external resync input enabled by TRIGGER_SEQ_SYNC_EN.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CNT_WIDTH   = TRIG_CNT_WIDTH,
  parameter int unsigned BURST_WIDTH = TRIG_BURST_WIDTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [CNT_WIDTH-1:0]          divider,
  input  logic [CHANNELS*CNT_WIDTH-1:0] phase,
  input  logic [BURST_WIDTH-1:0]        burst_len,
  input  logic                          start,
  input  logic                          stop,
`ifdef TRIGGER_SEQ_SYNC_EN
  input  logic                          sync_in,
`endif
  output logic [CHANNELS-1:0]           trigger,
  output logic                          busy,
  output logic                          done,
  output logic [BURST_WIDTH-1:0]        period_cnt
);

  trig_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BURST_WIDTH-1:0] period_q, period_d;
  logic                   done_q, done_d;
  logic                   load_c;
  logic                   wrap_c;
  logic                   last_period_c;
  logic                   sync_rise_c;

  logic [CNT_WIDTH-1:0]   div_s;
  logic [BURST_WIDTH-1:0] burst_s;
  logic [CNT_WIDTH-1:0]   phase_s [CHANNELS];

`ifdef TRIGGER_SEQ_SYNC_EN
  trigger_sync_edge u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (sync_in),
    .rise_c   (sync_rise_c)
  );
`else
  assign sync_rise_c = 1'b0;
`endif

  assign wrap_c        = (cnt_q == div_s);
  assign last_period_c = (burst_s != '0) && ((period_q + BURST_WIDTH'(1)) == burst_s);

  // State, counter and status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      done_q   <= done_d;
    end
  end

  // Shadow copies of the run configuration, captured on start
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_s   <= '0;
      burst_s <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) phase_s[ch] <= '0;
    end else if (load_c) begin
      div_s   <= divider;
      burst_s <= burst_len;
      for (int ch = 0; ch < CHANNELS; ch++) phase_s[ch] <= phase[ch*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  // Next-state, counter and period bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    done_d   = 1'b0;
    load_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop && (divider != '0)) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          period_d = '0;
          load_c   = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sync_rise_c) begin
          // Resync restarts the period without counting it as completed
          cnt_d = '0;
        end else if (wrap_c) begin
          cnt_d = '0;
          if (period_q != '1) period_d = period_q + BURST_WIDTH'(1);
          if (last_period_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-channel phase compare
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    assign trigger[ch] = (state_q == ST_RUN) && (cnt_q == phase_s[ch]);
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign period_cnt = period_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed testbench for trigger_sequencer (2 channels).
// Sync scenario is exercised only when TRIGGER_SEQ_SYNC_EN is defined.
module tb_trigger_sequencer;

  localparam int unsigned CH = 2;
  localparam int unsigned CW = 32;
  localparam int unsigned BW = 16;

  logic           clk;
  logic           resetn;
  logic [CW-1:0]  divider;
  logic [CH*CW-1:0] phase;
  logic [BW-1:0]  burst_len;
  logic           start;
  logic           stop;
  logic           sync_in;
  logic [CH-1:0]  trigger;
  logic           busy;
  logic           done;
  logic [BW-1:0]  period_cnt;

  int total;
  int bad;

  trigger_sequencer #(
    .CHANNELS    (CH),
    .CNT_WIDTH   (CW),
    .BURST_WIDTH (BW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .divider    (divider),
    .phase      (phase),
    .burst_len  (burst_len),
    .start      (start),
    .stop       (stop),
`ifdef TRIGGER_SEQ_SYNC_EN
    .sync_in    (sync_in),
`endif
    .trigger    (trigger),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; divider = '0; phase = '0; burst_len = '0;
    start = 1'b0; stop = 1'b0; sync_in = 1'b0;
    #2;
    total++;
    if ({trigger, busy, done, period_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got trig=%b busy=%b done=%b pc=%0d exp all 0",
               trigger, busy, done, period_cnt);
    end
    step(); step();
    resetn = 1'b1;
    step();
    total++;
    if ({trigger, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_release got trig=%b busy=%b done=%b exp 0", trigger, busy, done);
    end
  endtask

  // divider=4, phase={2,0}, continuous; mid-run start and divider change ignored
  task automatic test_continuous();
    logic [1:0] exp_t;
    divider = 32'd4; phase = {32'd2, 32'd0}; burst_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_t[0] = ((k - 1) % 5 == 0);
      exp_t[1] = ((k - 1) % 5 == 2);
      total++;
      if (trigger !== exp_t || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL cont_cycle k=%0d got trig=%b busy=%b done=%b exp trig=%b busy=1 done=0",
                 k, trigger, busy, done, exp_t);
      end
      if (k == 3) divider = 32'd7;
      if (k == 7) start = 1'b1;
      if (k == 8) start = 1'b0;
      if (k == 12) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    divider = 32'd4;
    for (int k = 13; k <= 15; k++) begin
      total++;
      if (trigger !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL cont_after_stop k=%0d got trig=%b busy=%b done=%b exp 0",
                 k, trigger, busy, done);
      end
      step();
    end
  endtask

  // divider=2, phase0=0, burst_len=3
  task automatic test_burst();
    logic exp_t0;
    divider = 32'd2; phase = {32'd1, 32'd0}; burst_len = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      exp_t0 = ((k - 1) % 3 == 0);
      total++;
      if (trigger[0] !== exp_t0 || busy !== 1'b1 || done !== 1'b0 ||
          period_cnt !== BW'((k - 1) / 3)) begin
        bad++;
        $display("FAIL burst_cycle k=%0d got t0=%b busy=%b done=%b pc=%0d exp t0=%b busy=1 done=0 pc=%0d",
                 k, trigger[0], busy, done, period_cnt, exp_t0, (k - 1) / 3);
      end
      step();
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b1 || period_cnt !== 16'd3 || trigger !== 2'b00) begin
      bad++;
      $display("FAIL burst_end got busy=%b done=%b pc=%0d trig=%b exp busy=0 done=1 pc=3 trig=00",
               busy, done, period_cnt, trigger);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || period_cnt !== 16'd3) begin
      bad++;
      $display("FAIL burst_done_pulse got done=%b busy=%b pc=%0d exp done=0 busy=0 pc=3",
               done, busy, period_cnt);
    end
  endtask

  // divider=3, phase1=5 never fires; phase0=0 unaffected
  task automatic test_phase_range();
    logic exp_t0;
    int   t1_hits;
    divider = 32'd3; phase = {32'd5, 32'd0}; burst_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    t1_hits = 0;
    for (int k = 1; k <= 20; k++) begin
      exp_t0 = ((k - 1) % 4 == 0);
      if (trigger[1]) t1_hits++;
      total++;
      if (trigger[0] !== exp_t0) begin
        bad++;
        $display("FAIL range_t0 k=%0d got=%b exp=%b", k, trigger[0], exp_t0);
      end
      step();
    end
    total++;
    if (t1_hits != 0) begin
      bad++;
      $display("FAIL range_t1 got hits=%0d exp 0", t1_hits);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Stop at t+5 of a continuous run, divider=0 start, start+stop together
  task automatic test_stop_and_ignore();
    divider = 32'd4; phase = {32'd2, 32'd0}; burst_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_pre got busy=%b exp 1", busy);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int k = 6; k <= 12; k++) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || trigger !== 2'b00) begin
        bad++;
        $display("FAIL stop_after k=%0d got busy=%b done=%b trig=%b exp 0",
                 k, busy, done, trigger);
      end
      step();
    end
    divider = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (busy !== 1'b0 || trigger !== 2'b00 || done !== 1'b0) begin
        bad++;
        $display("FAIL div_zero k=%0d got busy=%b trig=%b done=%b exp 0", k, busy, trigger, done);
      end
      step();
    end
    divider = 32'd4;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0 || trigger !== 2'b00) begin
      bad++;
      $display("FAIL start_stop_idle got busy=%b trig=%b exp 0", busy, trigger);
    end
  endtask

  // Asynchronous reset in the middle of a burst, then a fresh burst
  task automatic test_reset_mid_burst();
    divider = 32'd2; phase = {32'd1, 32'd0}; burst_len = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    total++;
    if (busy !== 1'b1 || period_cnt !== 16'd1) begin
      bad++;
      $display("FAIL rst_pre got busy=%b pc=%0d exp busy=1 pc=1", busy, period_cnt);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({trigger, busy, done, period_cnt} !== '0) begin
      bad++;
      $display("FAIL rst_async got trig=%b busy=%b done=%b pc=%0d exp all 0",
               trigger, busy, done, period_cnt);
    end
    step(); step();
    resetn = 1'b1;
    step();
    test_burst();
  endtask

`ifdef TRIGGER_SEQ_SYNC_EN
  // divider=9, sync_in rises while counter=4
  task automatic test_sync();
    divider = 32'd9; phase = {32'd3, 32'd0}; burst_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    sync_in = 1'b1;
    for (int k = 5; k <= 18; k++) begin
      if (k == 6 || k == 7) begin
        total++;
        if (trigger[0] !== 1'b0) begin
          bad++;
          $display("FAIL sync_gap k=%0d got t0=%b exp 0", k, trigger[0]);
        end
      end
      if (k == 8) begin
        total++;
        if (trigger[0] !== 1'b1 || period_cnt !== 16'd0) begin
          bad++;
          $display("FAIL sync_restart got t0=%b pc=%0d exp t0=1 pc=0", trigger[0], period_cnt);
        end
      end
      if (k == 18) begin
        total++;
        if (trigger[0] !== 1'b1 || period_cnt !== 16'd1) begin
          bad++;
          $display("FAIL sync_next got t0=%b pc=%0d exp t0=1 pc=1", trigger[0], period_cnt);
        end
      end
      step();
    end
    sync_in = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_continuous();
    test_burst();
    test_phase_range();
    test_stop_and_ignore();
    test_reset_mid_burst();
`ifdef TRIGGER_SEQ_SYNC_EN
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
